// File: rtl/uart_byte_rx.sv
// UART byte receiver: oversampled async RX line -> deframed 8N1 (8E1 with UART_RX_PARITY_EN) bytes.
// Latency: BYTE_VALID one cycle after stop-bit mid-sample (~9.5*CLKS_PER_BIT+3 cycles from RX fall).
// Backpressure: none; BYTE_VALID/FRAME_ERR are single-cycle strobes the consumer must take as they come.
//
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop (11-bit frame).
// Ports:
//   CLK        - clock, all logic on rising edge
//   RESET      - synchronous active-high reset
//   RX         - asynchronous serial input, idle high, LSB first
//   BYTE       - last good received byte, held until the next good frame
//   BYTE_VALID - 1-cycle pulse when BYTE has just been updated
//   FRAME_ERR  - 1-cycle pulse on bad stop bit (or bad parity)
//   BUSY       - high whenever the receiver is not idle
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] BYTE,
    output logic       BYTE_VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Last count of a full bit period, and of the half period used to reach mid start bit.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_WAITHI = 3'd5
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
`ifdef UART_RX_PARITY_EN
    logic            par_err;
`endif

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            BYTE       <= 8'h00;
            BYTE_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            rx_meta    <= RX;
            rx_s       <= rx_meta;
            BYTE_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;

            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) state <= S_START;
                end

                S_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        // Line back high at mid start bit: treat as a glitch, no report.
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        // Even parity: data bits plus parity bit must XOR to zero.
                        par_err <= (^shreg) ^ rx_s;
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        if (rx_s && !par_err) begin
`else
                        if (rx_s) begin
`endif
                            BYTE       <= shreg;
                            BYTE_VALID <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            FRAME_ERR  <= 1'b1;
                            state      <= S_WAITHI;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                S_WAITHI: begin
                    // Hold off on a break / stuck-low line so it is not read as a new start bit.
                    clk_cnt <= '0;
                    if (rx_s) state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule
